// File: rtl/rom_arb_pkg.sv
// Shared defaults and response record for the ROM read arbiter.
// The default record fits four requesters; the top builds its own record from its parameters.
package rom_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_DATA_W    = 7;
  localparam int DEF_ROM_DEPTH = 102;
  localparam int DEF_ID_W      = $clog2(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic                  err;
    logic [DEF_DATA_W-1:0] data;
  } rsp_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rom_rsp_fifo.sv
// Two-entry response FIFO with registered head; push and pop may coincide at any fill level.
module rom_rsp_fifo
  import rom_arb_pkg::*;
#(
  parameter type entry_t = rsp_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     din,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     slot0;
  entry_t     slot1;
  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            slot0 <= din;
            cnt   <= 2'd1;
          end else if (cnt == 2'd1) begin
            slot1 <= din;
            cnt   <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt != 2'd0) begin
            slot0 <= slot1;
            cnt   <= cnt - 2'd1;
          end
        end
        2'b11: begin
          // A pop on an empty FIFO cannot happen upstream, so treat it as a plain push.
          if (cnt == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
            cnt   <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign count = cnt;

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of one registered-read ROM between NUM_REQ requesters,
// with tagged responses returned through a 2-entry FIFO under valid/ready.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROM_DEPTH = DEF_ROM_DEPTH,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_data
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_found;
  logic [ADDR_W-1:0] sel_addr;
  logic              addr_ok;
  logic              can_issue;
  logic              accept;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;

  logic              inflight_vld;
  logic [ID_W-1:0]   inflight_id;
  logic              inflight_err;

  entry_t            fifo_in;
  entry_t            fifo_head;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  assign sel_addr = req_addr[gnt_id*ADDR_W +: ADDR_W];
  assign addr_ok  = addr_in_range(int'(sel_addr), ROM_DEPTH);

  // Credit covers both the stored entries and the read still travelling through the ROM.
  assign pop       = rsp_valid & rsp_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_vld} - {2'b00, pop};
  assign can_issue = occupancy < 3'd2;
  assign accept    = rst_n & can_issue & gnt_found;

  assign req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;
  assign rom_addr  = (accept && addr_ok) ? sel_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_vld <= 1'b0;
      inflight_id  <= '0;
      inflight_err <= 1'b0;
    end else begin
      inflight_vld <= accept;
      inflight_id  <= gnt_id;
      inflight_err <= ~addr_ok;
    end
  end

  always_comb begin
    fifo_in      = '0;
    fifo_in.id   = inflight_id;
    fifo_in.err  = inflight_err;
    fifo_in.data = inflight_err ? '0 : rom_data;
  end

  rom_rsp_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_vld),
    .din   (fifo_in),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign rsp_valid = fifo_count != 2'd0;
  assign rsp_id    = fifo_head.id;
  assign rsp_err   = fifo_head.err;
  assign rsp_data  = fifo_head.data;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Randomised scoreboard bench for rom_read_arbiter with a timestamped-queue reference model.
module tb_rom_read_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 7;
  localparam int ROM_DEPTH = 102;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_err;
  logic [DATA_W-1:0]         rsp_data;

  rom_read_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ROM_DEPTH (ROM_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom_mem [0:127];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    int id;
    int err;
    int data;
    int t;
  } exp_t;

  exp_t model_q[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ptr_m  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_REQ*ADDR_W-1:0] all_addr(input logic [ADDR_W-1:0] a);
    return {NUM_REQ{a}};
  endfunction

  // One cycle: drive, predict from the model, compare, then advance the model.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*ADDR_W-1:0] a,
                      input logic rr);
    int   exp_rv;
    int   exp_pop;
    int   outstanding;
    int   g;
    int   idx;
    int   addr;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    #1;
    exp_rv      = (model_q.size() > 0 && cyc >= model_q[0].t + 2) ? 1 : 0;
    exp_pop     = exp_rv & int'(rr);
    outstanding = model_q.size() - exp_pop;
    g           = -1;
    if (outstanding < 2) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (ptr_m + k) % NUM_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    addr = (g >= 0) ? int'(a[g*ADDR_W +: ADDR_W]) : 0;
    check("rsp_valid", int'(rsp_valid), exp_rv);
    check("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
    check("rom_addr", int'(rom_addr), (g >= 0 && addr < ROM_DEPTH) ? addr : 0);
    if (exp_pop != 0) void'(model_q.pop_front());
    if (g >= 0) begin
      e.id   = g;
      e.err  = (addr >= ROM_DEPTH) ? 1 : 0;
      e.data = (addr >= ROM_DEPTH) ? 0 : int'(rom_mem[addr]);
      e.t    = cyc;
      model_q.push_back(e);
      sb_q.push_back(e);
      ptr_m = (g + 1) % NUM_REQ;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step('0, '0, rr);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    req_addr  = all_addr(7'd5);
    rsp_ready = 1'b1;
    model_q.delete();
    sb_q.delete();
    ptr_m = 0;
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_fields", int'({rsp_id, rsp_err, rsp_data}), 0);
    cyc++;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    cyc++;
  endtask

  // Monitor: whenever a response is presented it must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          check("rsp_id", int'(rsp_id), sb_q[0].id);
          check("rsp_err", int'(rsp_err), sb_q[0].err);
          check("rsp_data", int'(rsp_data), sb_q[0].data);
          if (rsp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [NUM_REQ-1:0]        rv;
    logic [NUM_REQ*ADDR_W-1:0] ra;
    logic                      rr;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 128; i++) rom_mem[i] = 7'($urandom_range(0, 127));
    rom_mem[5] = 7'b0010010;
    do_reset(3);

    // Single read from requester 0.
    step(4'b0001, all_addr(7'd5), 1'b1);
    idle(4, 1'b1);

    // All requesters continuously: 0,1,2,3,0,...
    for (int i = 0; i < 12; i++) step(4'b1111, all_addr(7'(i * 7)), 1'b1);
    idle(4, 1'b1);

    // Backpressure with requester 1 always valid; one pop lets exactly one more in.
    for (int i = 0; i < 5; i++) step(4'b0010, all_addr(7'(10 + i)), 1'b0);
    step(4'b0010, all_addr(7'd20), 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0010, all_addr(7'd21), 1'b0);
    idle(6, 1'b1);

    // Last valid address then first out-of-range one, back to back.
    step(4'b0100, all_addr(7'd101), 1'b1);
    step(4'b0100, all_addr(7'd102), 1'b1);
    step(4'b0100, all_addr(7'd127), 1'b1);
    idle(4, 1'b1);

    // Reset one cycle after an accept discards the read and rewinds the pointer.
    do_reset(2);
    step(4'b0001, all_addr(7'd5), 1'b1);
    do_reset(1);
    idle(4, 1'b1);
    step(4'b1111, all_addr(7'd3), 1'b1);
    idle(4, 1'b1);

    // Pointer at 1 with only requester 3 valid, then 0 and 3 together.
    do_reset(2);
    step(4'b0001, all_addr(7'd1), 1'b1);
    step(4'b1000, all_addr(7'd2), 1'b1);
    step(4'b1001, all_addr(7'd4), 1'b1);
    idle(4, 1'b1);

    for (int n = 0; n < 500; n++) begin
      rv = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) ra[i*ADDR_W +: ADDR_W] = 7'($urandom_range(0, 127));
      rr = ($urandom_range(0, 9) < 7);
      step(rv, ra, rr);
    end
    idle(8, 1'b1);
    check("drain_scoreboard", sb_q.size(), 0);
    check("drain_model", model_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
